hilo_muldiv_unit: RTL

- Execution-stage consumer of the ALU control word and HI/LO write enable produced by the arithmetic control decoder.
- Executes MULT and DIV iteratively over multiple cycles and owns the architectural HI and LO registers.
- Serves MFHI and MFLO reads from HI and LO.
- Raises a stall to the non-pipelined core while an operation is in flight, so a dependent MFHI/MFLO or a back-to-back MULT/DIV waits.

---
 rtl/hilo_muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | hilo_muldiv_unit: iterative signed MULT/DIV owning HI/LO, with MFHI/MFLO reads |
// | Revision 1.0                                                                   |
// +------------------------------------------------------------------------------+
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       aluControl,
  input  logic             regHiLoWrite,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] hiLoData,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Subset of the libAlu operation encoding that this unit responds to
  localparam logic [3:0] ALU_MULT = 4'd8;
  localparam logic [3:0] ALU_DIV  = 4'd9;
  localparam logic [3:0] ALU_MFHI = 4'd10;
  localparam logic [3:0] ALU_MFLO = 4'd11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;
  logic               neg_a;
  logic               neg_b;
  logic               div_zero;
  logic               is_div;

  logic               is_muldiv_op;
  logic               is_hilo_op;
  logic               start;
  logic               last_iter;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   orig_a;

  assign is_muldiv_op = (aluControl == ALU_MULT) || (aluControl == ALU_DIV);
  assign is_hilo_op   = is_muldiv_op || (aluControl == ALU_MFHI) || (aluControl == ALU_MFLO);
  assign start        = (state == S_IDLE) && regHiLoWrite && is_muldiv_op;
  assign stall        = busy && is_hilo_op;
  assign last_iter    = (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes are plain unsigned, so the most negative value keeps its bit pattern
  assign abs_a = srcA[WIDTH-1] ? -srcA : srcA;
  assign abs_b = srcB[WIDTH-1] ? -srcB : srcB;

  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opb};

  assign prod_signed = (neg_a ^ neg_b) ? -prod : prod;
  assign quo_signed  = (neg_a ^ neg_b) ? -quo : quo;
  assign rem_signed  = neg_a ? -rem : rem;
  assign orig_a      = neg_a ? -opa : opa;

  always_comb begin
    hiLoData = '0;
    if (aluControl == ALU_MFHI) begin
      hiLoData = hi;
    end else if (aluControl == ALU_MFLO) begin
      hiLoData = lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      quo      <= '0;
      rem      <= '0;
      prod     <= '0;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            opa      <= abs_a;
            opb      <= abs_b;
            neg_a    <= srcA[WIDTH-1];
            neg_b    <= srcB[WIDTH-1];
            div_zero <= (srcB == '0);
            is_div   <= (aluControl == ALU_DIV);
            prod     <= {{WIDTH{1'b0}}, abs_b};
            quo      <= abs_a;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= (aluControl == ALU_DIV) ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (last_iter) state <= S_FIX;
        end
        S_DIV: begin
          // Keep the trial subtraction only when it did not borrow
          if (!div_diff[WIDTH+1]) begin
            rem <= div_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (last_iter) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            if (div_zero) begin
              hi <= orig_a;
              lo <= '1;
            end else begin
              hi <= rem_signed;
              lo <= quo_signed;
            end
          end else begin
            {hi, lo} <= prod_signed;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
